// File: rtl/writeback_queue_if.sv
// rtl/writeback_queue_if.sv - result inputs and register-file write port of writeback_queue
interface writeback_queue_if #(
  parameter int DATA_W = 64
);
  logic              alu_valid;
  logic [5:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_valid;
  logic [5:0]        ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic [DATA_W-1:0] wrt_data;
  logic [5:0]        rd;
  logic              RegWrite;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    input  wrt_data, rd, RegWrite
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    output wrt_data, rd, RegWrite
  );
endinterface

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order ALU/load result FIFO draining into the register file write port
module writeback_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  writeback_queue_if.slave  wb,
  input  logic [5:0]        rs1,
  input  logic [5:0]        rs2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  logic [4:0]        mem_rd   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  ld_slot;
  logic              alu_enq;
  logic              ld_enq;
  logic              deq;
  logic              unused_bits;

  assign unused_bits = ^{wb.alu_rd[5], wb.ld_rd[5], rs1[5], rs2[5]};

  // Readies look only at occupancy before the edge; a same-cycle dequeue never makes room.
  assign wb.alu_ready = count < CNT_W'(DEPTH);
  assign wb.ld_ready  = wb.alu_valid ? (count < CNT_W'(DEPTH - 1)) : (count < CNT_W'(DEPTH));

  // x0 results complete the handshake but are dropped here.
  assign alu_enq = wb.alu_valid && wb.alu_ready && (wb.alu_rd[4:0] != 5'd0);
  assign ld_enq  = wb.ld_valid && wb.ld_ready && (wb.ld_rd[4:0] != 5'd0);
  assign deq     = count != '0;
  assign ld_slot = wr_ptr + PTR_W'(alu_enq);

  assign full  = count == CNT_W'(DEPTH);
  assign empty = count == '0;

  always_ff @(posedge clk) begin
    if (alu_enq) begin
      mem_rd[wr_ptr]   <= wb.alu_rd[4:0];
      mem_data[wr_ptr] <= wb.alu_data;
    end
    if (ld_enq) begin
      mem_rd[ld_slot]   <= wb.ld_rd[4:0];
      mem_data[ld_slot] <= wb.ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wb.RegWrite <= 1'b0;
      wb.wrt_data <= '0;
      wb.rd       <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(alu_enq) + PTR_W'(ld_enq);
      count  <= count + CNT_W'(alu_enq) + CNT_W'(ld_enq) - CNT_W'(deq);
      if (deq) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        wb.RegWrite <= 1'b1;
        wb.wrt_data <= mem_data[rd_ptr];
        wb.rd       <= {1'b0, mem_rd[rd_ptr]};
      end else begin
        wb.RegWrite <= 1'b0;
      end
    end
  end

  // Scan oldest to youngest (output stage first) so the last match is the youngest value.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    idx       = rd_ptr;
    if (wb.RegWrite && rs1[4:0] != 5'd0 && wb.rd[4:0] == rs1[4:0]) begin
      fwd1_hit  = 1'b1;
      fwd1_data = wb.wrt_data;
    end
    if (wb.RegWrite && rs2[4:0] != 5'd0 && wb.rd[4:0] == rs2[4:0]) begin
      fwd2_hit  = 1'b1;
      fwd2_data = wb.wrt_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if (rs1[4:0] != 5'd0 && mem_rd[idx] == rs1[4:0]) begin
          fwd1_hit  = 1'b1;
          fwd1_data = mem_data[idx];
        end
        if (rs2[4:0] != 5'd0 && mem_rd[idx] == rs2[4:0]) begin
          fwd2_hit  = 1'b1;
          fwd2_data = mem_data[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - scoreboard bench for writeback_queue
module tb_writeback_queue;
  logic        clk;
  logic        reset;
  logic [5:0]  rs1;
  logic [5:0]  rs2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [63:0] fwd1_data;
  logic [63:0] fwd2_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [69:0] sb[$];

  writeback_queue_if #(.DATA_W(64)) wb ();

  writeback_queue #(.DATA_W(64), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .wb(wb),
    .rs1(rs1), .rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb.alu_valid = 1'b0;
    wb.ld_valid  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && wb.RegWrite) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0h data=%0h, expected no write", wb.rd, wb.wrt_data);
      end else begin
        logic [69:0] e;
        e = sb.pop_front();
        check("wr_rd", 64'(wb.rd), 64'(e[69:64]));
        check("wr_data", wb.wrt_data, e[63:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  int  bp_cnt[5] = '{0, 2, 3, 3, 3};
  bit  bp_lr[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  bit  bp_av[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    reset = 1'b1;
    rs1 = 6'd0;
    rs2 = 6'd0;
    wb.alu_valid = 1'b0; wb.alu_rd = 6'd0; wb.alu_data = '0;
    wb.ld_valid  = 1'b0; wb.ld_rd  = 6'd0; wb.ld_data  = '0;
    step();
    step();
    check("rst_regwrite", 64'(wb.RegWrite), 0);
    check("rst_wrt_data", wb.wrt_data, 0);
    check("rst_rd", 64'(wb.rd), 0);
    check("rst_count", 64'(count), 0);
    check("rst_empty", 64'(empty), 1);
    check("rst_full", 64'(full), 0);
    check("rst_alu_ready", 64'(wb.alu_ready), 1);
    check("rst_ld_ready", 64'(wb.ld_ready), 1);
    check("rst_fwd1_hit", 64'(fwd1_hit), 0);
    check("rst_fwd1_data", fwd1_data, 0);
    reset = 1'b0;

    // basic drain
    wb.alu_valid = 1'b1; wb.alu_rd = 6'd5; wb.alu_data = 64'h1234;
    rs1 = 6'd5;
    #1;
    check("b_alu_ready", 64'(wb.alu_ready), 1);
    sb.push_back({6'd5, 64'h1234});
    step();
    idle_inputs();
    #1;
    check("b_count1", 64'(count), 1);
    check("b_regwrite0", 64'(wb.RegWrite), 0);
    check("b_fwd_hit_q", 64'(fwd1_hit), 1);
    check("b_fwd_data_q", fwd1_data, 64'h1234);
    step();
    check("b_regwrite1", 64'(wb.RegWrite), 1);
    check("b_count0", 64'(count), 0);
    check("b_fwd_hit_out", 64'(fwd1_hit), 1);
    step();
    check("b_regwrite_off", 64'(wb.RegWrite), 0);
    check("b_count_end", 64'(count), 0);
    check("b_hold_data", wb.wrt_data, 64'h1234);
    check("b_hold_rd", 64'(wb.rd), 5);
    check("b_fwd_miss", 64'(fwd1_hit), 0);
    check("b_fwd_miss_data", fwd1_data, 0);

    // simultaneous accept, load is younger
    wb.alu_valid = 1'b1; wb.alu_rd = 6'd3; wb.alu_data = 64'hA;
    wb.ld_valid  = 1'b1; wb.ld_rd  = 6'd3; wb.ld_data  = 64'hB;
    rs1 = 6'd3;
    #1;
    check("s_alu_ready", 64'(wb.alu_ready), 1);
    check("s_ld_ready", 64'(wb.ld_ready), 1);
    sb.push_back({6'd3, 64'hA});
    sb.push_back({6'd3, 64'hB});
    step();
    idle_inputs();
    #1;
    check("s_count2", 64'(count), 2);
    check("s_fwd_young", fwd1_data, 64'hB);
    step();
    check("s_out_first", wb.wrt_data, 64'hA);
    check("s_fwd_over_out", fwd1_data, 64'hB);
    step();
    check("s_out_second", wb.wrt_data, 64'hB);
    check("s_fwd_out", 64'(fwd1_hit), 1);
    step();
    check("s_fwd_gone", 64'(fwd1_hit), 0);

    // rd bit 5 is ignored on inputs and queries
    wb.alu_valid = 1'b1; wb.alu_rd = 6'h2A; wb.alu_data = 64'h77;
    rs2 = 6'h2A;
    sb.push_back({6'h0A, 64'h77});
    step();
    idle_inputs();
    #1;
    check("h_fwd2_hit", 64'(fwd2_hit), 1);
    check("h_fwd2_data", fwd2_data, 64'h77);
    step();
    check("h_rd_bit5", 64'(wb.rd), 64'h0A);
    step();

    // x0 filtering
    wb.alu_valid = 1'b1; wb.alu_rd = 6'd0;  wb.alu_data = 64'hFF;
    wb.ld_valid  = 1'b1; wb.ld_rd  = 6'h20; wb.ld_data  = 64'hEE;
    rs2 = 6'd0;
    #1;
    check("z_alu_ready", 64'(wb.alu_ready), 1);
    check("z_ld_ready", 64'(wb.ld_ready), 1);
    step();
    idle_inputs();
    #1;
    check("z_count", 64'(count), 0);
    check("z_empty", 64'(empty), 1);
    check("z_fwd2_hit", 64'(fwd2_hit), 0);
    step();
    check("z_no_write", 64'(wb.RegWrite), 0);
    step();

    // backpressure with both sources held valid
    for (int k = 0; k < 5; k++) begin
      wb.alu_valid = bp_av[k]; wb.alu_rd = 6'(8 + k);  wb.alu_data = 64'h100 + 64'(k);
      wb.ld_valid  = 1'b1;     wb.ld_rd  = 6'(16 + k); wb.ld_data  = 64'h200 + 64'(k);
      #1;
      check("p_count", 64'(count), 64'(bp_cnt[k]));
      check("p_alu_ready", 64'(wb.alu_ready), 1);
      check("p_ld_ready", 64'(wb.ld_ready), 64'(bp_lr[k]));
      check("p_full", 64'(full), 0);
      if (bp_av[k]) sb.push_back({6'(8 + k), 64'h100 + 64'(k)});
      if (bp_lr[k]) sb.push_back({6'(16 + k), 64'h200 + 64'(k)});
      step();
    end
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      step();
      check("p_drain_bound", 64'(count <= 3'd3), 1);
    end
    check("p_drained", 64'(count), 0);

    // forwarding lifetime
    wb.alu_valid = 1'b1; wb.alu_rd = 6'd7; wb.alu_data = 64'h55;
    rs1 = 6'd7;
    #1;
    check("l_pre_hit", 64'(fwd1_hit), 0);
    sb.push_back({6'd7, 64'h55});
    step();
    idle_inputs();
    #1;
    check("l_q_hit", 64'(fwd1_hit), 1);
    check("l_q_data", fwd1_data, 64'h55);
    check("l_q_nowrite", 64'(wb.RegWrite), 0);
    step();
    check("l_out_write", 64'(wb.RegWrite), 1);
    check("l_out_rd", 64'(wb.rd), 7);
    check("l_out_hit", 64'(fwd1_hit), 1);
    step();
    check("l_after_hit", 64'(fwd1_hit), 0);
    check("l_after_data", fwd1_data, 0);

    // asynchronous reset mid-drain
    wb.alu_valid = 1'b1; wb.alu_rd = 6'd1; wb.alu_data = 64'h11;
    wb.ld_valid  = 1'b1; wb.ld_rd  = 6'd2; wb.ld_data  = 64'h22;
    sb.push_back({6'd1, 64'h11});
    step();
    wb.alu_rd = 6'd3; wb.alu_data = 64'h33;
    wb.ld_rd  = 6'd4; wb.ld_data  = 64'h44;
    #1;
    check("r_ld_ready", 64'(wb.ld_ready), 1);
    step();
    idle_inputs();
    check("r_count3", 64'(count), 3);
    check("r_out_rd", 64'(wb.rd), 1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    rs1 = 6'd2;
    #1;
    check("r_regwrite", 64'(wb.RegWrite), 0);
    check("r_count", 64'(count), 0);
    check("r_wrt_data", wb.wrt_data, 0);
    check("r_rd", 64'(wb.rd), 0);
    check("r_empty", 64'(empty), 1);
    check("r_fwd_hit", 64'(fwd1_hit), 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("r_no_stale", 64'(wb.RegWrite), 0);
    end
    check("sb_empty", 64'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
